// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide issue path: op codes,
// op-class helpers and the issue FSM state encoding.
package mdu_pkg;

    localparam int OP_CODE_W = 4;

    localparam logic [OP_CODE_W-1:0] OP_MULT  = 4'd1;
    localparam logic [OP_CODE_W-1:0] OP_MULTU = 4'd2;
    localparam logic [OP_CODE_W-1:0] OP_MTHI  = 4'd3;
    localparam logic [OP_CODE_W-1:0] OP_MTLO  = 4'd4;
    localparam logic [OP_CODE_W-1:0] OP_MFHI  = 4'd5;
    localparam logic [OP_CODE_W-1:0] OP_MFLO  = 4'd6;
    localparam logic [OP_CODE_W-1:0] OP_DIV   = 4'd7;
    localparam logic [OP_CODE_W-1:0] OP_DIVU  = 4'd8;
    localparam logic [OP_CODE_W-1:0] OP_MADD  = 4'd9;
    localparam logic [OP_CODE_W-1:0] OP_MADDU = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE
    } md_state_t;

    // Writers modify HI/LO and therefore go through the MD unit's Start path.
    function automatic logic is_writer(input logic [OP_CODE_W-1:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO,
                          OP_DIV, OP_DIVU, OP_MADD, OP_MADDU};
    endfunction

    function automatic logic is_reader(input logic [OP_CODE_W-1:0] op);
        return op inside {OP_MFHI, OP_MFLO};
    endfunction

    function automatic logic is_long(input logic [OP_CODE_W-1:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU};
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// E-stage initiator for the HI/LO multiply/divide unit: issues Start with
// registered operands, stalls E on MD hazards and rolls HI/LO back on a kill.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int COMMIT_DEPTH = 2,
    parameter int OP_W         = OP_CODE_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            md_valid,
    input  logic [OP_W-1:0] md_op,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     rt_val,
    input  logic            pipe_adv,
    input  logic            kill,
    input  logic            busy,
    output logic            start,
    output logic [OP_W-1:0] xalu_op,
    output logic [31:0]     d1,
    output logic [31:0]     d2,
    output logic            rollback,
    output logic            stall_e
);

    localparam int              CNT_W    = $clog2(COMMIT_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMMIT_DEPTH);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [OP_W-1:0]  op_q;
    logic [CNT_W-1:0] pend_cnt;
    logic             writer;
    logic             reader;
    logic             pending;
    logic             accept;

    assign writer  = is_writer(md_op);
    assign reader  = is_reader(md_op);
    assign pending = (pend_cnt != '0);

    // A writer also waits for the previous writer to commit, so the unit's
    // saved HI/LO copy is never overwritten while a rollback is still possible.
    assign stall_e = md_valid & ((state != IDLE) | busy | (writer & pending));
    assign accept  = md_valid & ~stall_e & ~kill & pipe_adv;

    // NOTE: every output of this block gets a default first so no path through
    // the case statement leaves a variable unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        xalu_op   = '0;
        case (state)
            IDLE: begin
                if (accept && writer) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = SETTLE;
                start     = ~kill;
                xalu_op   = op_q;
            end
            SETTLE: begin
                // busy is only meaningful one cycle after Start.
                if (!busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != ISSUE && md_valid && reader && !stall_e) xalu_op = md_op;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= '0;
            d1   <= '0;
            d2   <= '0;
        end else if (accept && writer) begin
            op_q <= md_op;
            d1   <= rs_val;
            d2   <= rt_val;
        end
    end

    // A kill while an issued writer is still uncommitted restores HI/LO; a kill
    // in ISSUE never reaches here because Start is suppressed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_cnt <= '0;
            rollback <= 1'b0;
        end else begin
            rollback <= kill & pending;
            if (kill) begin
                pend_cnt <= '0;
            end else if (start) begin
                pend_cnt <= CNT_LOAD;
            end else if (pipe_adv && pending) begin
                pend_cnt <= pend_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: expected Start transactions are queued
// when an op is accepted and compared when Start appears.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    localparam int COMMIT_DEPTH = 2;
    localparam int OP_W         = 4;

    logic            clk      = 1'b0;
    logic            reset_n  = 1'b1;
    logic            md_valid = 1'b0;
    logic [OP_W-1:0] md_op    = '0;
    logic [31:0]     rs_val   = '0;
    logic [31:0]     rt_val   = '0;
    logic            pipe_adv = 1'b1;
    logic            kill     = 1'b0;
    logic            busy     = 1'b0;
    logic            start;
    logic [OP_W-1:0] xalu_op;
    logic [31:0]     d1;
    logic [31:0]     d2;
    logic            rollback;
    logic            stall_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [31:0]     a;
        logic [31:0]     b;
    } start_t;

    start_t sb[$];
    int     checks  = 0;
    int     failures = 0;
    int     rb_seen = 0;

    mdu_issue_ctrl #(.COMMIT_DEPTH(COMMIT_DEPTH), .OP_W(OP_W)) dut (
        .clk(clk), .reset_n(reset_n), .md_valid(md_valid), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .pipe_adv(pipe_adv), .kill(kill),
        .busy(busy), .start(start), .xalu_op(xalu_op), .d1(d1), .d2(d2),
        .rollback(rollback), .stall_e(stall_e)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard and rollback sampling on the falling edge, then step past
    // the next rising edge.
    task automatic tick();
        start_t e;
        @(negedge clk);
        if (start === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_start", 32'(start), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_xalu_op", 32'(xalu_op), 32'(e.op));
                check("sb_d1", d1, e.a);
                check("sb_d2", d2, e.b);
            end
        end
        if (rollback === 1'b1) rb_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
        md_valid = 1'b1;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        #1;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        while (stall_e === 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int rb0;

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check("rst_start", 32'(start), 32'd0);
        check("rst_xalu_op", 32'(xalu_op), 32'd0);
        check("rst_d1", d1, 32'd0);
        check("rst_rollback", 32'(rollback), 32'd0);
        check("rst_stall", 32'(stall_e), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // 1: mult 3 x 0xFFFFFFFC, mflo behind it
        drive(OP_MULT, 32'd3, 32'hFFFF_FFFC);
        check("t1_mult_no_stall", 32'(stall_e), 32'd0);
        sb.push_back(start_t'({OP_MULT, 32'd3, 32'hFFFF_FFFC}));
        tick();
        drive(OP_MFLO, 32'd0, 32'd0);
        check("t1_start", 32'(start), 32'd1);
        check("t1_xalu_op", 32'(xalu_op), 32'd1);
        check("t1_d1", d1, 32'd3);
        check("t1_d2", d2, 32'hFFFF_FFFC);
        check("t1_mflo_stall_issue", 32'(stall_e), 32'd1);
        tick();
        busy = 1'b1;
        #1;
        check("t1_mflo_stall_busy", 32'(stall_e), 32'd1);
        check("t1_xalu_idle", 32'(xalu_op), 32'd0);
        tick();
        tick();
        check("t1_mflo_stall_busy2", 32'(stall_e), 32'd1);
        busy = 1'b0;
        #1;
        check("t1_mflo_stall_settle", 32'(stall_e), 32'd1);
        tick();
        check("t1_mflo_go", 32'(stall_e), 32'd0);
        check("t1_mflo_xalu", 32'(xalu_op), 32'(OP_MFLO));
        tick();
        md_valid = 1'b0;

        // 2: divu by zero, busy never rises; mfhi stalls ISSUE + SETTLE
        repeat (3) tick();
        drive(OP_DIVU, 32'd7, 32'd0);
        check("t2_divu_no_stall", 32'(stall_e), 32'd0);
        sb.push_back(start_t'({OP_DIVU, 32'd7, 32'd0}));
        tick();
        check("t2_state_issue", 32'(dut.state), 32'(ISSUE));
        drive(OP_MFHI, 32'd0, 32'd0);
        count_stall(n);
        check("t2_mfhi_stall_cycles", 32'(n), 32'd2);
        check("t2_state_idle", 32'(dut.state), 32'(IDLE));
        check("t2_mfhi_xalu", 32'(xalu_op), 32'(OP_MFHI));
        tick();
        md_valid = 1'b0;

        // 3: mthi then mult; mult waits for mthi to commit (ISSUE + COMMIT_DEPTH)
        repeat (3) tick();
        drive(OP_MTHI, 32'h1234_5678, 32'd0);
        check("t3_mthi_no_stall", 32'(stall_e), 32'd0);
        sb.push_back(start_t'({OP_MTHI, 32'h1234_5678, 32'd0}));
        tick();
        drive(OP_MULT, 32'd5, 32'd6);
        count_stall(n);
        check("t3_mult_stall_cycles", 32'(n), 32'(COMMIT_DEPTH + 1));
        check("t3_pend_zero", 32'(dut.pend_cnt), 32'd0);
        sb.push_back(start_t'({OP_MULT, 32'd5, 32'd6}));
        tick();
        md_valid = 1'b0;
        #1;
        check("t3_mult_start", 32'(start), 32'd1);
        tick();
        busy = 1'b1;
        tick();
        busy = 1'b0;
        tick();
        check("t3_state_idle", 32'(dut.state), 32'(IDLE));

        // 4: kill during ISSUE suppresses Start and needs no rollback
        repeat (3) tick();
        rb0 = rb_seen;
        drive(OP_MULT, 32'd9, 32'd10);
        check("t4_mult_no_stall", 32'(stall_e), 32'd0);
        tick();
        md_valid = 1'b0;
        kill = 1'b1;
        #1;
        check("t4_start_killed", 32'(start), 32'd0);
        tick();
        kill = 1'b0;
        #1;
        check("t4_state_settle", 32'(dut.state), 32'(SETTLE));
        check("t4_pend_zero", 32'(dut.pend_cnt), 32'd0);
        check("t4_no_rollback", 32'(rollback), 32'd0);
        tick();
        check("t4_state_idle", 32'(dut.state), 32'(IDLE));
        check("t4_rb_count", 32'(rb_seen - rb0), 32'd0);

        // 5: madd killed one cycle after Start: single rollback pulse
        drive(OP_MADD, 32'd2, 32'd3);
        check("t5_madd_no_stall", 32'(stall_e), 32'd0);
        sb.push_back(start_t'({OP_MADD, 32'd2, 32'd3}));
        tick();
        md_valid = 1'b0;
        #1;
        check("t5_start", 32'(start), 32'd1);
        tick();
        rb0 = rb_seen;
        busy = 1'b1;
        kill = 1'b1;
        drive(OP_MULTU, 32'd4, 32'd5);
        check("t5_multu_stall_kill", 32'(stall_e), 32'd1);
        tick();
        kill = 1'b0;
        #1;
        check("t5_rb_pulse", 32'(rollback), 32'd1);
        check("t5_pend_cleared", 32'(dut.pend_cnt), 32'd0);
        check("t5_state_settle", 32'(dut.state), 32'(SETTLE));
        check("t5_multu_stall_rb", 32'(stall_e), 32'd1);
        tick();
        check("t5_rb_clear", 32'(rollback), 32'd0);
        check("t5_multu_stall_busy", 32'(stall_e), 32'd1);
        tick();
        busy = 1'b0;
        #1;
        check("t5_multu_stall_settle", 32'(stall_e), 32'd1);
        tick();
        check("t5_multu_go", 32'(stall_e), 32'd0);
        sb.push_back(start_t'({OP_MULTU, 32'd4, 32'd5}));
        tick();
        md_valid = 1'b0;
        tick();
        tick();
        check("t5_rb_count", 32'(rb_seen - rb0), 32'd1);

        // 6: asynchronous reset while SETTLE waits on busy
        repeat (3) tick();
        drive(OP_MULT, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        sb.push_back(start_t'({OP_MULT, 32'hA5A5_A5A5, 32'h5A5A_5A5A}));
        tick();
        md_valid = 1'b0;
        tick();
        busy = 1'b1;
        tick();
        check("t6_pre_state", 32'(dut.state), 32'(SETTLE));
        check("t6_pre_d1", d1, 32'hA5A5_A5A5);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_start", 32'(start), 32'd0);
        check("t6_rst_xalu", 32'(xalu_op), 32'd0);
        check("t6_rst_d1", d1, 32'd0);
        check("t6_rst_d2", d2, 32'd0);
        check("t6_rst_rollback", 32'(rollback), 32'd0);
        check("t6_rst_stall", 32'(stall_e), 32'd0);
        check("t6_rst_state", 32'(dut.state), 32'(IDLE));
        check("t6_rst_pend", 32'(dut.pend_cnt), 32'd0);
        tick();
        reset_n = 1'b1;
        drive(OP_MFHI, 32'd0, 32'd0);
        check("t6_mfhi_stall_busy", 32'(stall_e), 32'd1);
        tick();
        busy = 1'b0;
        #1;
        check("t6_mfhi_go", 32'(stall_e), 32'd0);
        check("t6_mfhi_xalu", 32'(xalu_op), 32'(OP_MFHI));
        tick();
        md_valid = 1'b0;
        tick();
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
